// File: rtl/seq_det_param_mealy.sv
// Runtime-programmable serial bit-sequence detector with a Mealy match output.
// Supports overlapping or non-overlapping detection, valid-qualified input and a saturating match counter.
module seq_det_param_mealy #(
    parameter int unsigned        SEQ_LEN     = 3,
    parameter logic [SEQ_LEN-1:0] SEQ_DEFAULT = 3'b110,
    parameter int unsigned        CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               overlap,
    input  logic [SEQ_LEN-1:0] pattern,
    input  logic               pattern_load,
    input  logic               cnt_clr,
    output logic               out,
    output logic               out_q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    localparam int unsigned       FILL_W   = $clog2(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [SEQ_LEN-1:0] pat;
    logic [SEQ_LEN-2:0] hist;
    logic [SEQ_LEN-2:0] hist_shift;
    logic [FILL_W-1:0]  fill;
    logic               match;

    // A 2-bit pattern keeps only one history bit, so the shift collapses to a copy.
    generate
        if (SEQ_LEN == 2) begin : g_hist_one
            assign hist_shift = in;
        end else begin : g_hist_many
            assign hist_shift = {hist[SEQ_LEN-3:0], in};
        end
    endgenerate

    always_comb begin
        match = in_valid & ~pattern_load & (fill == FILL_MAX) & ({hist, in} == pat);
    end

    assign out     = match;
    assign cnt_sat = (match_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            pat  <= SEQ_DEFAULT;
            hist <= '0;
            fill <= '0;
        end else if (pattern_load) begin
            pat  <= pattern;
            hist <= '0;
            fill <= '0;
        end else if (in_valid) begin
            if (match && !overlap) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= hist_shift;
                fill <= (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= match;
        end
    end

    // A clear coinciding with a match keeps that match in the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= match ? CNT_ONE : '0;
        end else if (match && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_seq_det_param_mealy.sv
// Scoreboard bench: driver pushes per-cycle expectations from a queue-based model;
// an independent monitor pops and compares them against the DUT outputs.
module tb_seq_det_param_mealy;

    localparam int unsigned L    = 3;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = (1 << CW) - 1;
    localparam logic [L-1:0] DEF = 3'b110;

    logic          clk = 1'b0;
    logic          rst, din, in_valid, overlap, pattern_load, cnt_clr;
    logic [L-1:0]  pattern;
    logic          out, out_q, cnt_sat;
    logic [CW-1:0] match_cnt;

    seq_det_param_mealy #(
        .SEQ_LEN    (L),
        .SEQ_DEFAULT(DEF),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (din),
        .in_valid    (in_valid),
        .overlap     (overlap),
        .pattern     (pattern),
        .pattern_load(pattern_load),
        .cnt_clr     (cnt_clr),
        .out         (out),
        .out_q       (out_q),
        .match_cnt   (match_cnt),
        .cnt_sat     (cnt_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int o;
        int oq;
        int cnt;
        int sat;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: valid bits since the last flush, newest at the back.
    int       mbits[$];
    logic [L-1:0] mpat;
    int       mcnt;
    int       mout_q;
    bit       mvalid = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_match(input logic v, input logic b, input logic ld);
        int val;
        if (!v || ld || mbits.size() != L - 1) return 0;
        val = 0;
        foreach (mbits[i]) val = val * 2 + mbits[i];
        val = val * 2 + int'(b);
        return int'(val == int'(mpat));
    endfunction

    task automatic cycle(input logic r, input logic v, input logic b, input logic ov,
                         input logic ld, input logic [L-1:0] p, input logic clr);
        int m;
        @(negedge clk);
        rst = r; in_valid = v; din = b; overlap = ov;
        pattern_load = ld; pattern = p; cnt_clr = clr;
        m = model_match(v, b, ld);
        if (mvalid) expq.push_back('{m, mout_q, mcnt, int'(mcnt == CMAX)});
        if (r) begin
            mbits.delete();
            mpat   = DEF;
            mcnt   = 0;
            mout_q = 0;
            mvalid = 1;
        end else begin
            mout_q = m;
            if (clr) mcnt = m;
            else if (m != 0 && mcnt < CMAX) mcnt = mcnt + 1;
            if (ld) begin
                mbits.delete();
                mpat = p;
            end else if (v) begin
                if (m != 0 && !ov) begin
                    mbits.delete();
                end else begin
                    mbits.push_back(int'(b));
                    if (mbits.size() > L - 1) void'(mbits.pop_front());
                end
            end
        end
        #1;
    endtask

    task automatic bit_in(input logic b, input logic ov);
        cycle(1'b0, 1'b1, b, ov, 1'b0, '0, 1'b0);
    endtask

    task automatic idle(input logic b);
        cycle(1'b0, 1'b0, b, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic load(input logic [L-1:0] p, input logic clr);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, p, clr);
    endtask

    // Monitor: every cycle the DUT presents out/out_q/match_cnt/cnt_sat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("sb_out",   int'(out),       e.o);
                chk("sb_out_q", int'(out_q),     e.oq);
                chk("sb_cnt",   int'(match_cnt), e.cnt);
                chk("sb_sat",   int'(cnt_sat),   e.sat);
            end
        end
    end

    initial begin
        rst = 1; din = 0; in_valid = 0; overlap = 1; pattern_load = 0; cnt_clr = 0;
        pattern = '0;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        idle(1'b1);
        chk("rst_out", int'(out), 0);
        chk("rst_cnt", int'(match_cnt), 0);

        // T1: default 110, overlapping
        bit_in(1, 1); bit_in(1, 1); bit_in(0, 1);
        chk("t1_out_b3", int'(out), 1);
        bit_in(1, 1); bit_in(1, 1); bit_in(0, 1);
        chk("t1_out_b6", int'(out), 1);
        idle(0);
        chk("t1_cnt", int'(match_cnt), 2);

        // T2: 101 overlapping, then non-overlapping
        load(3'b101, 1'b1);
        bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
        chk("t2_ov_b3", int'(out), 1);
        bit_in(0, 1); bit_in(1, 1);
        chk("t2_ov_b5", int'(out), 1);
        load(3'b101, 1'b1);
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 0);
        chk("t2_nov_b3", int'(out), 1);
        bit_in(0, 0); bit_in(1, 0);
        chk("t2_nov_b5", int'(out), 0);
        idle(0);
        chk("t2_cnt", int'(match_cnt), 1);

        // T3: bubbles between valid bits
        load(3'b110, 1'b0);
        bit_in(1, 1); idle(0); idle(1);
        bit_in(1, 1); idle(1); idle(0);
        chk("t3_bubble", int'(out), 0);
        bit_in(0, 1);
        chk("t3_out", int'(out), 1);

        // T4: load discards in-flight bits
        bit_in(1, 1); bit_in(1, 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0);
        chk("t4_load_out", int'(out), 0);
        bit_in(0, 1); bit_in(1, 1);
        chk("t4_mid", int'(out), 0);
        bit_in(1, 1);
        chk("t4_out", int'(out), 1);

        // T5: saturation and clear-with-match
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            bit_in(0, 1); bit_in(1, 1); bit_in(1, 1);
        end
        idle(0);
        chk("t5_cnt_sat", int'(match_cnt), 3);
        chk("t5_sat", int'(cnt_sat), 1);
        bit_in(0, 1); bit_in(1, 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        chk("t5_clr_out", int'(out), 1);
        idle(0);
        chk("t5_clr_cnt", int'(match_cnt), 1);

        // T6: reset mid-pattern restores default
        load(3'b110, 1'b0);
        bit_in(1, 1); bit_in(1, 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        bit_in(0, 1);
        chk("t6_out", int'(out), 0);
        chk("t6_cnt", int'(match_cnt), 0);
        chk("t6_out_q", int'(out_q), 0);
        load(3'b011, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        bit_in(1, 1); bit_in(1, 1); bit_in(0, 1);
        chk("t6_default", int'(out), 1);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0),
                  L'($urandom), ($urandom_range(0, 24) == 0));
        end

        repeat (4) @(negedge clk);
        #3;
        chk("sb_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
